// File: rtl/player_ctrl_if.sv
// player_ctrl_if: keycode/enemy inputs and player-state outputs of the player controller.
// master = the controller, slave = keyboard/spawner/colour-mapper side.
interface player_ctrl_if #(
  parameter int N_ENEMY = 4
);
  logic [23:0]              keycode;
  logic [N_ENEMY-1:0][9:0]  enemy_x;
  logic [N_ENEMY-1:0][9:0]  enemy_y;
  logic [N_ENEMY-1:0][9:0]  enemy_size;
  logic [N_ENEMY-1:0]       enemy_alive;
  logic [9:0]               PlayerX;
  logic [9:0]               PlayerY;
  logic [9:0]               PlayerS;
  logic [N_ENEMY-1:0]       hit_vec;
  logic                     player_die;
  logic [3:0]               lives_left;
  logic                     visible;
  logic                     game_over;

  modport master (
    input  keycode, enemy_x, enemy_y, enemy_size, enemy_alive,
    output PlayerX, PlayerY, PlayerS, hit_vec, player_die, lives_left, visible, game_over
  );

  modport slave (
    output keycode, enemy_x, enemy_y, enemy_size, enemy_alive,
    input  PlayerX, PlayerY, PlayerS, hit_vec, player_die, lives_left, visible, game_over
  );
endinterface

// File: rtl/player_ctrl.sv
// player_ctrl: per-frame WASD mover with play-field clamp, N-enemy box collision and lives/respawn FSM.
// Latency: every output is registered on the frame_clk edge it is computed for; no backpressure, one update per frame.
module player_ctrl #(
  parameter int N_ENEMY       = 4,
  parameter int SIZE          = 8,
  parameter int STEP          = 3,
  parameter int X_MIN         = 3,
  parameter int X_MAX         = 636,
  parameter int Y_MIN         = 3,
  parameter int Y_MAX         = 476,
  parameter int START_X       = 320,
  parameter int START_Y       = 450,
  parameter int LIVES         = 3,
  parameter int DEATH_FRAMES  = 30,
  parameter int INVULN_FRAMES = 60
) (
  input  logic          frame_clk,
  input  logic          Reset,
  player_ctrl_if.master pif
);

  localparam int CNT_MAX = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
  localparam int CW      = (CNT_MAX > 8) ? $clog2(CNT_MAX) : 3;

  localparam logic [10:0]   R      = 11'(SIZE / 2);
  localparam logic [10:0]   STP    = 11'(STEP);
  localparam logic [10:0]   X_LO   = 11'(X_MIN + SIZE / 2);
  localparam logic [10:0]   X_HI   = 11'(X_MAX - SIZE / 2);
  localparam logic [10:0]   Y_LO   = 11'(Y_MIN + SIZE / 2);
  localparam logic [10:0]   Y_HI   = 11'(Y_MAX - SIZE / 2);
  localparam logic [CW-1:0] DEATH_LOAD  = CW'(DEATH_FRAMES - 1);
  localparam logic [CW-1:0] INVULN_LOAD = CW'(INVULN_FRAMES - 1);

  typedef enum logic [1:0] {ALIVE, DYING, INVULN, GAME_OVER} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_dec;
  logic [9:0]         pos_x, pos_y;
  logic [N_ENEMY-1:0] hit_q;
  logic               die_q, vis_q, go_q;
  logic [3:0]         lives_q;

  logic               key_a, key_d, key_w, key_s;
  logic [10:0]        x11, y11;
  logic [9:0]         x_next, y_next;
  logic [N_ENEMY-1:0] ov;

  assign x11     = {1'b0, pos_x};
  assign y11     = {1'b0, pos_y};
  assign cnt_dec = cnt - CW'(1);

  always_comb begin
    key_a = 1'b0;
    key_d = 1'b0;
    key_w = 1'b0;
    key_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (pif.keycode[8*k +: 8] == 8'h04) key_a = 1'b1;
      if (pif.keycode[8*k +: 8] == 8'h07) key_d = 1'b1;
      if (pif.keycode[8*k +: 8] == 8'h1A) key_w = 1'b1;
      if (pif.keycode[8*k +: 8] == 8'h16) key_s = 1'b1;
    end
  end

  // Clamp is written as a pre-check so the 11-bit subtract never underflows.
  always_comb begin
    x_next = pos_x;
    y_next = pos_y;
    if (key_a && !key_d)
      x_next = (x11 >= X_LO + STP) ? 10'(x11 - STP) : 10'(X_LO);
    else if (key_d && !key_a)
      x_next = (x11 + STP <= X_HI) ? 10'(x11 + STP) : 10'(X_HI);
    if (key_w && !key_s)
      y_next = (y11 >= Y_LO + STP) ? 10'(y11 - STP) : 10'(Y_LO);
    else if (key_s && !key_w)
      y_next = (y11 + STP <= Y_HI) ? 10'(y11 + STP) : 10'(Y_HI);
  end

  always_comb begin
    ov = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      ov[i] = pif.enemy_alive[i]
            & (x11 - R < {1'b0, pif.enemy_x[i]} + {1'b0, pif.enemy_size[i]})
            & (x11 + R > {1'b0, pif.enemy_x[i]})
            & (y11 - R < {1'b0, pif.enemy_y[i]} + {1'b0, pif.enemy_size[i]})
            & (y11 + R > {1'b0, pif.enemy_y[i]});
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state   <= ALIVE;
      cnt     <= '0;
      pos_x   <= 10'(START_X);
      pos_y   <= 10'(START_Y);
      hit_q   <= '0;
      die_q   <= 1'b0;
      lives_q <= 4'(LIVES);
      vis_q   <= 1'b1;
      go_q    <= 1'b0;
    end else begin
      hit_q <= ov;
      die_q <= 1'b0;
      case (state)
        ALIVE: begin
          if (|ov) begin
            die_q   <= 1'b1;
            lives_q <= (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
            cnt     <= DEATH_LOAD;
            vis_q   <= 1'b0;
            state   <= DYING;
          end else begin
            pos_x <= x_next;
            pos_y <= y_next;
          end
        end
        DYING: begin
          vis_q <= 1'b0;
          cnt   <= cnt_dec;
          if (cnt == '0) begin
            if (lives_q == 4'd0) begin
              go_q  <= 1'b1;
              vis_q <= 1'b1;
              state <= GAME_OVER;
            end else begin
              pos_x <= 10'(START_X);
              pos_y <= 10'(START_Y);
              cnt   <= INVULN_LOAD;
              vis_q <= INVULN_LOAD[2];
              state <= INVULN;
            end
          end
        end
        INVULN: begin
          pos_x <= x_next;
          pos_y <= y_next;
          // visible tracks bit 2 of the counter value it now holds: 4 frames on, 4 off.
          if (cnt == '0) begin
            vis_q <= 1'b1;
            state <= ALIVE;
          end else begin
            cnt   <= cnt_dec;
            vis_q <= cnt_dec[2];
          end
        end
        GAME_OVER: begin
          go_q  <= 1'b1;
          vis_q <= 1'b1;
        end
        default: state <= ALIVE;
      endcase
    end
  end

  assign pif.PlayerX    = pos_x;
  assign pif.PlayerY    = pos_y;
  assign pif.PlayerS    = 10'(SIZE);
  assign pif.hit_vec    = hit_q;
  assign pif.player_die = die_q;
  assign pif.lives_left = lives_q;
  assign pif.visible    = vis_q;
  assign pif.game_over  = go_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus random keys/enemies against a frame-level model.
module tb_player_ctrl;
  localparam int N   = 4;
  localparam int SZ  = 8;
  localparam int STP = 3;
  localparam int XMN = 3, XMX = 636, YMN = 3, YMX = 476;
  localparam int SX  = 320, SY = 450;
  localparam int LV  = 3, DF = 30, IF = 60;
  localparam int R   = SZ / 2;

  logic frame_clk = 1'b0;
  logic Reset;
  player_ctrl_if #(.N_ENEMY(N)) pif ();

  player_ctrl #(
    .N_ENEMY(N), .SIZE(SZ), .STEP(STP), .X_MIN(XMN), .X_MAX(XMX), .Y_MIN(YMN), .Y_MAX(YMX),
    .START_X(SX), .START_Y(SY), .LIVES(LV), .DEATH_FRAMES(DF), .INVULN_FRAMES(IF)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .pif(pif)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  // Model: player position, lives, and remaining frozen / immune frames.
  int m_x, m_y, m_lives, m_frozen, m_immune;
  bit m_die, m_vis, m_go;
  logic [N-1:0] m_hit;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pressed(logic [7:0] code);
    return (pif.keycode[23:16] == code) || (pif.keycode[15:8] == code) || (pif.keycode[7:0] == code);
  endfunction

  function automatic int mv(int p, bit neg, bit pos, int lo, int hi);
    if (neg && !pos) return (p - STP < lo) ? lo : p - STP;
    if (pos && !neg) return (p + STP > hi) ? hi : p + STP;
    return p;
  endfunction

  function automatic logic [N-1:0] overlaps(int px, int py);
    logic [N-1:0] o = '0;
    for (int i = 0; i < N; i++) begin
      int ex = int'(pif.enemy_x[i]);
      int ey = int'(pif.enemy_y[i]);
      int es = int'(pif.enemy_size[i]);
      o[i] = pif.enemy_alive[i] && (px - R < ex + es) && (px + R > ex) && (py - R < ey + es) && (py + R > ey);
    end
    return o;
  endfunction

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_x = SX; m_y = SY; m_lives = LV; m_frozen = 0; m_immune = 0;
      m_die = 0; m_vis = 1; m_go = 0; m_hit = '0;
    end else begin
      logic [N-1:0] o;
      int nx, ny;
      o     = overlaps(m_x, m_y);
      nx    = mv(m_x, pressed(8'h04), pressed(8'h07), XMN + R, XMX - R);
      ny    = mv(m_y, pressed(8'h1A), pressed(8'h16), YMN + R, YMX - R);
      m_hit = o;
      m_die = 0;
      if (m_go) begin
        m_vis = 1;
      end else if (m_frozen > 0) begin
        m_frozen--;
        m_vis = 0;
        if (m_frozen == 0) begin
          if (m_lives == 0) begin
            m_go = 1; m_vis = 1;
          end else begin
            m_x = SX; m_y = SY; m_immune = IF;
            m_vis = (((m_immune - 1) >> 2) & 1) != 0;
          end
        end
      end else if (m_immune > 0) begin
        m_x = nx; m_y = ny;
        m_immune--;
        m_vis = (m_immune == 0) ? 1'b1 : ((((m_immune - 1) >> 2) & 1) != 0);
      end else if (o != '0) begin
        m_die = 1;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_frozen = DF;
        m_vis = 0;
      end else begin
        m_x = nx; m_y = ny;
      end
    end
  end

  always @(negedge frame_clk) begin
    if (chk_en) begin
      chk("PlayerX", int'(pif.PlayerX), m_x);
      chk("PlayerY", int'(pif.PlayerY), m_y);
      chk("PlayerS", int'(pif.PlayerS), SZ);
      chk("hit_vec", int'(pif.hit_vec), int'(m_hit));
      chk("player_die", int'(pif.player_die), int'(m_die));
      chk("lives_left", int'(pif.lives_left), m_lives);
      chk("visible", int'(pif.visible), int'(m_vis));
      chk("game_over", int'(pif.game_over), int'(m_go));
    end
  end

  task automatic frames(int n);
    repeat (n) begin
      @(posedge frame_clk);
      #2;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    frames(1);
    Reset = 1'b0;
  endtask

  task automatic set_enemy(int i, int x, int y, int s, bit a);
    pif.enemy_x[i]     = 10'(x);
    pif.enemy_y[i]     = 10'(y);
    pif.enemy_size[i]  = 10'(s);
    pif.enemy_alive[i] = a;
  endtask

  task automatic clear_enemies();
    for (int i = 0; i < N; i++) set_enemy(i, 0, 0, 1, 1'b0);
  endtask

  function automatic logic [7:0] rkey();
    case ($urandom_range(0, 6))
      0: return 8'h04;
      1: return 8'h07;
      2: return 8'h1A;
      3: return 8'h16;
      4: return 8'($urandom_range(0, 255));
      default: return 8'h00;
    endcase
  endfunction

  function automatic int near(int c);
    int v = c - 12 + int'($urandom_range(0, 23));
    return (v < 0) ? 0 : v;
  endfunction

  initial begin
    Reset = 1'b0;
    pif.keycode = '0;
    clear_enemies();
    #1 Reset = 1'b1;
    frames(2);
    Reset = 1'b0;
    chk_en = 1;

    // Idle after reset
    frames(10);
    chk("idle X", int'(pif.PlayerX), 320);
    chk("idle Y", int'(pif.PlayerY), 450);
    chk("idle lives", int'(pif.lives_left), 3);
    chk("idle visible", int'(pif.visible), 1);
    chk("idle die", int'(pif.player_die), 0);

    // Hold A to the left clamp, then D
    pif.keycode = 24'h00_00_04;
    frames(1);
    chk("A first step", int'(pif.PlayerX), 317);
    frames(199);
    chk("A clamp", int'(pif.PlayerX), 7);
    pif.keycode = 24'h00_00_07;
    frames(1);
    chk("D from clamp", int'(pif.PlayerX), 10);

    // Diagonal W+A, then A+D cancel
    pif.keycode = 24'h00_1A_04;
    frames(1);
    chk("WA X", int'(pif.PlayerX), 7);
    chk("WA Y", int'(pif.PlayerY), 447);
    pif.keycode = 24'h00_04_07;
    frames(3);
    chk("AD X", int'(pif.PlayerX), 7);

    // Single hit, death, respawn, blink, re-hit after immunity
    pif.keycode = '0;
    do_reset();
    set_enemy(0, 316, 446, 8, 1'b1);
    frames(1);
    chk("hit vec", int'(pif.hit_vec), 1);
    chk("hit die", int'(pif.player_die), 1);
    chk("hit lives", int'(pif.lives_left), 2);
    chk("hit visible", int'(pif.visible), 0);
    frames(1);
    chk("die pulse end", int'(pif.player_die), 0);
    frames(29);
    chk("respawn X", int'(pif.PlayerX), 320);
    chk("respawn Y", int'(pif.PlayerY), 450);
    chk("invuln vis0", int'(pif.visible), 0);
    frames(4);
    chk("invuln vis1", int'(pif.visible), 1);
    frames(56);
    chk("immune lives", int'(pif.lives_left), 2);
    chk("alive visible", int'(pif.visible), 1);
    frames(1);
    chk("rehit lives", int'(pif.lives_left), 1);

    // Edge-touching enemies are not hits
    do_reset();
    set_enemy(0, 324, 446, 8, 1'b1);
    set_enemy(1, 308, 446, 8, 1'b1);
    frames(2);
    chk("edge hit_vec", int'(pif.hit_vec), 0);
    chk("edge lives", int'(pif.lives_left), 3);

    // Double hit costs one life; held overlap runs to game over
    do_reset();
    set_enemy(0, 316, 446, 8, 1'b1);
    set_enemy(1, 318, 448, 6, 1'b1);
    frames(1);
    chk("double hit_vec", int'(pif.hit_vec), 3);
    chk("double lives", int'(pif.lives_left), 2);
    frames(212);
    chk("game_over", int'(pif.game_over), 1);
    chk("go lives", int'(pif.lives_left), 0);
    pif.keycode = 24'h00_00_04;
    frames(10);
    chk("go frozen X", int'(pif.PlayerX), 320);
    chk("go visible", int'(pif.visible), 1);

    // Reset mid-DYING
    clear_enemies();
    pif.keycode = 24'h00_00_07;
    do_reset();
    frames(5);
    chk("pre-death X", int'(pif.PlayerX), 335);
    pif.keycode = '0;
    set_enemy(0, 331, 446, 8, 1'b1);
    frames(1);
    chk("mid death die", int'(pif.player_die), 1);
    clear_enemies();
    frames(10);
    #1 Reset = 1'b1;
    #1;
    chk("async rst X", int'(pif.PlayerX), 320);
    chk("async rst lives", int'(pif.lives_left), 3);
    chk("async rst vis", int'(pif.visible), 1);
    chk("async rst go", int'(pif.game_over), 0);
    frames(1);
    Reset = 1'b0;

    // Random keys and enemies near the player
    for (int f = 0; f < 3000; f++) begin
      if ($urandom_range(0, 399) == 0 || (m_go && $urandom_range(0, 19) == 0)) begin
        do_reset();
      end else begin
        pif.keycode = {rkey(), rkey(), rkey()};
        for (int i = 0; i < N; i++)
          set_enemy(i, near(m_x), near(m_y), int'($urandom_range(1, 12)), $urandom_range(0, 11) == 0);
        frames(1);
      end
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Parametrised player-sprite controller; successor to the single-ball mover.
- Each frame it moves the player from WASD keycodes, with per-axis clamping to a play-field box.
- Tests the player against N_ENEMY enemy boxes, and runs a lives / death / respawn / invulnerability state machine.
- Sits between the keyboard keycode register, the enemy spawner and the colour mapper; clocked by the vertical-sync frame clock.

Parameters:
N_ENEMY, 4, number of enemy channels checked for collision
SIZE, 8, player box edge length in pixels (even, 2..32)
STEP, 3, pixels moved per frame per axis
X_MIN, 3, leftmost play-field pixel
X_MAX, 636, rightmost play-field pixel
Y_MIN, 3, topmost play-field pixel
Y_MAX, 476, bottommost play-field pixel
START_X, 320, spawn / respawn centre X
START_Y, 450, spawn / respawn centre Y
LIVES, 3, lives at reset (1..15)
DEATH_FRAMES, 30, frames spent frozen after a hit
INVULN_FRAMES, 60, frames of collision immunity after respawn

Ports:
frame_clk  in  1  frame clock; all state changes on its rising edge
Reset  in  1  asynchronous, active-high reset
keycode  in  24  three 8-bit key slots [23:16],[15:8],[7:0]
enemy_x  in  N_ENEMY x 10  enemy box left edge
enemy_y  in  N_ENEMY x 10  enemy box top edge
enemy_size  in  N_ENEMY x 10  enemy box edge length
enemy_alive  in  N_ENEMY  enemy valid flags
PlayerX  out  10  player centre X
PlayerY  out  10  player centre Y
PlayerS  out  10  constant SIZE
hit_vec  out  N_ENEMY  registered per-enemy overlap flags
player_die  out  1  one-frame pulse on a fatal hit
lives_left  out  4  remaining lives
visible  out  1  draw enable for the colour mapper (blink)
game_over  out  1  sticky until Reset

Behaviour:
Reset (async, active-high) values:
- PlayerX=START_X, PlayerY=START_Y, lives_left=LIVES, state=ALIVE.
- hit_vec=0, player_die=0, visible=1, game_over=0, frame counter=0.

Key decode:
- A=04h, D=07h, W=1Ah, S=16h; a key is pressed if it appears in any of the 3 slots.
- A and D both pressed: no X motion. W and S both pressed: no Y motion.
- The X and Y axes move independently, so diagonals are supported.

Motion (positions, not a motion register):
- The new position applies at the same edge; there is no one-frame lag.
- Let r=SIZE/2. Arithmetic is 11-bit unsigned, so there is no wrap-around.
- Left move: X' = max(X-STEP, X_MIN+r). Right move: X' = min(X+STEP, X_MAX-r). Y is handled the same way.
- At a bound, the player holds position; motion away from the bound is still allowed.
- Motion happens only in ALIVE and INVULN. In DYING and GAME_OVER the position is frozen.

Collision (combinational from the current registered position):
- ov[i] = enemy_alive[i] & (X-r < ex+es) & (X+r > ex) & (Y-r < ey+es) & (Y+r > ey).
- Comparisons are strict, so edge-touching is not a hit. Widths are 11 bits.
- hit_vec <= ov every frame, in every state.

State machine:
- ALIVE, any ov[i]=1 at an edge: player_die=1 for that frame and lives_left decrements (saturates at 0). Position is not updated that frame. Counter is loaded with DEATH_FRAMES-1. Go to DYING.
- DYING: counter decrements each frame and visible=0. When the counter is 0:
  - If lives_left==0, go to GAME_OVER.
  - Otherwise, set PlayerX/Y=START_X/Y, load counter with INVULN_FRAMES-1 and go to INVULN.
- INVULN: movement is enabled and collisions are ignored (hit_vec still reports). visible=counter[2], giving a blink every 4 frames. When the counter reaches 0, set visible=1 and go to ALIVE.
- GAME_OVER: game_over=1, visible=1, position frozen. Only Reset exits.
- Simultaneous hits on several enemies cost one life only.
- A Reset asserted in any state, mid-count, restores the reset values immediately.

Test Plan:
1. Reset, no keys, 10 frames -> PlayerX=320, PlayerY=450, lives_left=3, visible=1, player_die=0.
2. Hold A (keycode=00_00_04h) for 200 frames -> PlayerX steps 317, 314, ... and clamps at 7; then release A and hold D -> X increments by 3 starting the next frame.
3. Hold W+A in different slots (keycode=00_1A_04h) -> X and Y each decrease by 3 per frame; A+D together (00_04_07h) -> X unchanged.
4. enemy0 alive at (316,446,size 8) with the player at (320,450) -> the next edge gives hit_vec[0]=1, a one-frame player_die pulse and lives_left=2. After 30 frames the player is at (320,450) in INVULN and visible toggles every 4 frames. Enemy touching edge-only (ex=324) -> no hit.
5. Two enemies overlapping in the same frame -> lives_left drops by 1 only. Overlap held through INVULN -> no further decrement until ALIVE.
6. Three successive deaths -> game_over=1 after the third DYING, and keys have no effect. Assert Reset mid-DYING in a separate run -> state=ALIVE, lives_left=3, position (320,450).
